// File: rtl/idelay_tap_ctrl_if.sv
// Command channel between calibration/host logic and the IDELAYE2 tap controller.
// The host side drives a command and sees cmd_ready/cmd_err; the controller side answers.
interface idelay_tap_ctrl_if #(
    parameter int CHAN_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CHAN_W-1:0] cmd_chan;
    logic [4:0]        cmd_tap;
    logic              cmd_err;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_chan,
        output cmd_tap,
        input  cmd_ready,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_chan,
        input  cmd_tap,
        output cmd_ready,
        output cmd_err
    );
endinterface

// File: rtl/idelay_tap_ctrl.sv
// Run-time tap controller for a bank of VAR_LOAD IDELAYE2 lines sharing one IDELAYCTRL.
// Loads every line to IDELAY_VALUE after RDY, then serves load/inc/dec/default commands.
module idelay_tap_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int CHAN_W        = 2,
    parameter int IDELAY_VALUE  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctrl_rdy,
    idelay_tap_ctrl_if.slave      cmd,
    output logic [NUM_CH-1:0]     dly_ld,
    output logic [NUM_CH-1:0]     dly_ce,
    output logic [NUM_CH-1:0]     dly_inc,
    output logic [5*NUM_CH-1:0]   dly_cntvaluein,
    output logic [5*NUM_CH-1:0]   tap_value,
    output logic                  ready
);

    localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CHAN_W-1:0] LAST_CH  = CHAN_W'(NUM_CH - 1);
    localparam logic [4:0]        DEF_TAP  = 5'(IDELAY_VALUE);

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_INC     = 2'd1;
    localparam logic [1:0] OP_DEC     = 2'd2;
    localparam logic [1:0] OP_DEFAULT = 2'd3;

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_INIT,
        S_IDLE,
        S_APPLY,
        S_SETTLE
    } state_t;

    state_t            state_reg, state_next;
    logic [CHAN_W-1:0] idx_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        op_reg;
    logic [CHAN_W-1:0] chan_reg;
    logic [4:0]        tap_cmd_reg;
    logic              err_reg;
    logic              ready_reg;

    logic              accept;
    logic              reject;
    logic              chan_ok;
    logic [4:0]        cur_tap;
    logic              op_is_ld;
    logic [4:0]        apply_tap;

    // Every output is gated by ctrl_rdy so a RDY drop silences the pins in the same cycle.
    assign cmd.cmd_ready = ctrl_rdy && (state_reg == S_IDLE);
    assign cmd.cmd_err   = ctrl_rdy && err_reg;
    assign ready         = ctrl_rdy && ready_reg;

    assign op_is_ld  = (op_reg == OP_LOAD) || (op_reg == OP_DEFAULT);
    assign apply_tap = (op_reg == OP_LOAD) ? tap_cmd_reg : DEF_TAP;

    always_comb begin
        state_next = state_reg;
        cur_tap    = '0;
        chan_ok    = int'(cmd.cmd_chan) < NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cmd.cmd_chan) == i) begin
                cur_tap = tap_value[5*i +: 5];
            end
        end
        accept = cmd.cmd_valid && cmd.cmd_ready;
        // Saturation is judged against the shadow tap so the line never wraps 31<->0.
        reject = accept && (!chan_ok
                            || ((cmd.cmd_op == OP_INC) && (cur_tap == 5'd31))
                            || ((cmd.cmd_op == OP_DEC) && (cur_tap == 5'd0)));

        if (!ctrl_rdy) begin
            state_next = S_WAIT_RDY;
        end else begin
            case (state_reg)
                S_WAIT_RDY: state_next = S_INIT;
                S_INIT:     if (idx_reg == LAST_CH) state_next = S_SETTLE;
                S_IDLE:     if (accept && !reject) state_next = S_APPLY;
                S_APPLY:    state_next = S_SETTLE;
                S_SETTLE:   if (cnt_reg == CNT_LAST) state_next = S_IDLE;
                default:    state_next = S_WAIT_RDY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_WAIT_RDY;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            op_reg      <= '0;
            chan_reg    <= '0;
            tap_cmd_reg <= '0;
            err_reg     <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= (state_reg == S_INIT) ? idx_reg + CHAN_W'(1) : '0;
            cnt_reg   <= (state_reg == S_SETTLE) ? cnt_reg + CNT_W'(1) : '0;
            err_reg   <= reject;
            if (accept) begin
                op_reg      <= cmd.cmd_op;
                chan_reg    <= cmd.cmd_chan;
                tap_cmd_reg <= cmd.cmd_tap;
            end
            if (!ctrl_rdy) begin
                ready_reg <= 1'b0;
            end else if ((state_reg == S_SETTLE) && (state_next == S_IDLE)) begin
                ready_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic       sel_init;
            logic       sel_apply;
            logic       ld_en;
            logic       ce_en;
            logic [4:0] ld_val;
            logic [4:0] shadow_reg;
            logic [4:0] cntv_reg;

            assign sel_init  = (state_reg == S_INIT)  && (idx_reg  == CHAN_W'(gi));
            assign sel_apply = (state_reg == S_APPLY) && (chan_reg == CHAN_W'(gi));
            assign ld_en     = ctrl_rdy && (sel_init || (sel_apply && op_is_ld));
            assign ce_en     = ctrl_rdy && sel_apply && !op_is_ld;
            assign ld_val    = sel_init ? DEF_TAP : apply_tap;

            assign dly_ld[gi]              = ld_en;
            assign dly_ce[gi]              = ce_en;
            assign dly_inc[gi]             = ce_en && (op_reg == OP_INC);
            // CNTVALUEIN shows the new value during the LD pulse and holds it afterwards.
            assign dly_cntvaluein[5*gi +: 5] = ld_en ? ld_val : cntv_reg;
            assign tap_value[5*gi +: 5]      = shadow_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cntv_reg   <= '0;
                    shadow_reg <= DEF_TAP;
                end else if (ld_en) begin
                    cntv_reg   <= ld_val;
                    shadow_reg <= ld_val;
                end else if (ce_en) begin
                    shadow_reg <= (op_reg == OP_INC) ? shadow_reg + 5'd1 : shadow_reg - 5'd1;
                end
            end
        end
    endgenerate

endmodule
